// File: rtl/mw_writeback.sv
// M/W pipeline register and writeback-data generation feeding the GRF write port.
// Define LOAD_EXT_EN to enable byte/halfword load extension; otherwise loads are word-only.
module mw_writeback #(
   parameter logic [31:0] RESET_PC    = 32'h0000_3000,
   parameter logic [31:0] PC_LINK_OFF = 32'd8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        flush,
   input  logic [31:0] M_PC,
   input  logic [4:0]  M_A3,
   input  logic        M_RegWrite,
   input  logic [1:0]  M_WDSel,
   input  logic [31:0] M_ALUOut,
   input  logic [31:0] M_DMRD,
   input  logic [2:0]  M_LdType,
   input  logic [1:0]  M_ByteOff,
   output logic [31:0] W_PC,
   output logic [4:0]  W_A3,
   output logic        W_WE,
   output logic [31:0] W_WD,
   output logic        W_Valid
);

   typedef enum logic [1:0] {
      WD_ALU  = 2'd0,
      WD_LOAD = 2'd1,
      WD_LINK = 2'd2,
      WD_NONE = 2'd3
   } wdsel_e;

   logic [31:0] pc_q;
   logic [4:0]  a3_q;
   logic        rw_q;
   wdsel_e      wdsel_q;
   logic [31:0] alu_q;
   logic [31:0] dmrd_q;
   logic        valid_q;
   logic [31:0] ld_data;

`ifdef LOAD_EXT_EN
   typedef enum logic [2:0] {
      LD_W  = 3'd0,
      LD_B  = 3'd1,
      LD_BU = 3'd2,
      LD_H  = 3'd3,
      LD_HU = 3'd4
   } ldtype_e;

   ldtype_e     ldtype_q;
   logic [1:0]  byteoff_q;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         ldtype_q  <= LD_W;
         byteoff_q <= '0;
      end else if (en) begin
         ldtype_q  <= ldtype_e'(M_LdType);
         byteoff_q <= M_ByteOff;
      end
   end

   always_comb begin
      ld_byte = '0;
      case (byteoff_q)
         2'd0:    ld_byte = dmrd_q[7:0];
         2'd1:    ld_byte = dmrd_q[15:8];
         2'd2:    ld_byte = dmrd_q[23:16];
         default: ld_byte = dmrd_q[31:24];
      endcase
      // Halfword selection only looks at the upper offset bit
      ld_half = byteoff_q[1] ? dmrd_q[31:16] : dmrd_q[15:0];
      ld_data = dmrd_q;
      case (ldtype_q)
         LD_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
         LD_BU:   ld_data = {24'd0, ld_byte};
         LD_H:    ld_data = {{16{ld_half[15]}}, ld_half};
         LD_HU:   ld_data = {16'd0, ld_half};
         default: ld_data = dmrd_q;
      endcase
   end
`else
   logic unused_ldext;
   assign unused_ldext = ^{M_LdType, M_ByteOff};
   assign ld_data      = dmrd_q;
`endif

   // Reset and flush both leave a bubble; flush wins over en
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         pc_q    <= RESET_PC;
         a3_q    <= '0;
         rw_q    <= 1'b0;
         wdsel_q <= WD_ALU;
         alu_q   <= '0;
         dmrd_q  <= '0;
         valid_q <= 1'b0;
      end else if (en) begin
         pc_q    <= M_PC;
         a3_q    <= M_A3;
         rw_q    <= M_RegWrite;
         wdsel_q <= wdsel_e'(M_WDSel);
         alu_q   <= M_ALUOut;
         dmrd_q  <= M_DMRD;
         valid_q <= 1'b1;
      end
   end

   always_comb begin
      W_WD = '0;
      case (wdsel_q)
         WD_ALU:  W_WD = alu_q;
         WD_LOAD: W_WD = ld_data;
         WD_LINK: W_WD = pc_q + PC_LINK_OFF;
         default: W_WD = '0;
      endcase
   end

   assign W_PC    = pc_q;
   assign W_A3    = a3_q;
   assign W_Valid = valid_q;
   assign W_WE    = rw_q && valid_q && (a3_q != 5'd0);

endmodule
